// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage types and constants.
// The program counter and its next-address adder both build on these.
package cpu_pkg;

    localparam int PC_WIDTH     = 16;
    localparam int OFFSET_WIDTH = 9;

    typedef logic [PC_WIDTH-1:0]            pc_t;
    typedef logic signed [OFFSET_WIDTH-1:0] pc_offset_t;

    localparam pc_t PC_RESET = 16'h0000;

    // Two's-complement widening of a branch displacement to a full address.
    function automatic pc_t sign_extend_offset(input pc_offset_t offset);
        return {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
    endfunction

endpackage

// File: rtl/pc_next_adder.sv
// Sequential-address adder.
// Produces either PC + 1 or PC + sign-extended offset, modulo 2^PC_WIDTH.
module pc_next_adder
    import cpu_pkg::*;
(
    input  pc_t        i_pc,
    input  pc_offset_t i_offset,
    input  logic       i_use_offset,
    output pc_t        o_sum
);

    pc_t w_addend;

    always_comb begin
        w_addend = pc_t'(1);
        if (i_use_offset) begin
            w_addend = sign_extend_offset(i_offset);
        end
    end

    // The sum is truncated to PC_WIDTH, so both directions wrap naturally.
    assign o_sum = i_pc + w_addend;

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter.
// Each rising edge it either resets, jumps absolute, branches relative, or steps by one.
module program_counter
    import cpu_pkg::*;
#(
    parameter pc_t RESET_VALUE = PC_RESET
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       LoadEnable,
    input  pc_t        LoadValue,
    input  logic       OffsetEnable,
    input  pc_offset_t Offset,
    output pc_t        CounterValue
);

    pc_t  r_pc;
    pc_t  w_sum;
    pc_t  w_next_pc;

    // Registers that only remember the previous edge's controls for the checks below.
    logic r_seen_reset;
    logic r_prev_reset;
    logic r_prev_load;
    logic r_prev_offen;
    pc_t  r_prev_pc;

    pc_next_adder u_next_adder (
        .i_pc         (r_pc),
        .i_offset     (Offset),
        .i_use_offset (OffsetEnable),
        .o_sum        (w_sum)
    );

    // Priority: Reset > LoadEnable > OffsetEnable > increment.
    always_comb begin
        w_next_pc = w_sum;
        if (Reset) begin
            w_next_pc = RESET_VALUE;
        end else if (LoadEnable) begin
            w_next_pc = LoadValue;
        end
    end

    always_ff @(posedge Clock) begin
        r_pc <= w_next_pc;
    end

    assign CounterValue = r_pc;

    always_ff @(posedge Clock) begin
        r_seen_reset <= r_seen_reset | Reset;
        r_prev_reset <= Reset;
        r_prev_load  <= LoadEnable;
        r_prev_offen <= OffsetEnable;
        r_prev_pc    <= r_pc;
        if (r_seen_reset) begin
            assert (!$isunknown(r_pc))
                else $error("program counter is unknown after reset");
            if (r_prev_reset) begin
                assert (r_pc == RESET_VALUE)
                    else $error("program counter not at reset value after reset");
            end else if (!r_prev_load && !r_prev_offen) begin
                assert (r_pc == r_prev_pc + 16'd1)
                    else $error("program counter did not step by one");
            end
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed boundary cases then random control mixes,
// compared against an integer-arithmetic model of the counter.
module tb_program_counter;
    import cpu_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       LoadEnable = 1'b0;
    pc_t        LoadValue = '0;
    logic       OffsetEnable = 1'b0;
    pc_offset_t Offset = '0;
    pc_t        CounterValue;

    int n_compared   = 0;
    int n_mismatched = 0;
    int model_pc     = 0;

    program_counter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .LoadEnable   (LoadEnable),
        .LoadValue    (LoadValue),
        .OffsetEnable (OffsetEnable),
        .Offset       (Offset),
        .CounterValue (CounterValue)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of controls, let the edge happen, update the model, compare.
    task automatic run_cycle(input string tag, input logic rst, input logic ld, input logic [15:0] lv,
                             input logic oe, input logic [8:0] off);
        int disp;
        Reset        = rst;
        LoadEnable   = ld;
        LoadValue    = lv;
        OffsetEnable = oe;
        Offset       = off;
        @(posedge Clock);
        #1;
        disp = off[8] ? int'(off) - 512 : int'(off);
        if (rst)      model_pc = 0;
        else if (ld)  model_pc = int'(lv);
        else if (oe)  model_pc = (model_pc + disp) & 16'hFFFF;
        else          model_pc = (model_pc + 1) & 16'hFFFF;
        check_value(tag, CounterValue, model_pc[15:0]);
    endtask

    initial begin
        @(negedge Clock);

        // Reset held, then release and count up.
        for (int i = 0; i < 10; i++) run_cycle("reset_hold", 1, 0, 16'h0, 0, 9'h0);
        check_value("reset_const", CounterValue, 16'h0000);
        for (int i = 0; i < 3; i++) run_cycle("count_up", 0, 0, 16'h0, 0, 9'h0);
        check_value("count_up_const", CounterValue, 16'd3);

        // Load held, then free-run, then reset beats load.
        for (int i = 0; i < 5; i++) run_cycle("load_hold", 0, 1, 16'd8, 0, 9'h0);
        run_cycle("after_load", 0, 0, 16'd8, 0, 9'h0);
        check_value("after_load_const", CounterValue, 16'd9);
        run_cycle("after_load", 0, 0, 16'd8, 0, 9'h0);
        run_cycle("reset_over_load", 1, 1, 16'd8, 0, 9'h0);
        check_value("reset_over_load_const", CounterValue, 16'h0000);

        // Positive offsets and the zero-offset stall.
        for (int i = 0; i < 3; i++) run_cycle("offset_pos", 0, 0, 16'h0, 1, 9'd5);
        check_value("offset_pos_const", CounterValue, 16'd15);
        for (int i = 0; i < 2; i++) run_cycle("offset_stall", 0, 0, 16'h0, 1, 9'd0);
        check_value("offset_stall_const", CounterValue, 16'd15);

        // Negative offsets and wrap below zero.
        for (int i = 0; i < 3; i++) run_cycle("offset_neg", 0, 0, 16'h0, 1, 9'h1FF);
        run_cycle("reset_mid", 1, 0, 16'h0, 1, 9'h1FF);
        run_cycle("wrap_down", 0, 0, 16'h0, 1, 9'h1FF);
        check_value("wrap_down_const", CounterValue, 16'hFFFF);
        run_cycle("load_0100", 0, 1, 16'h0100, 0, 9'h0);
        run_cycle("offset_min", 0, 0, 16'h0, 1, 9'h100);
        check_value("offset_min_const", CounterValue, 16'h0000);

        // Increment wrap at the top of the address space.
        run_cycle("load_fffe", 0, 1, 16'hFFFE, 0, 9'h0);
        for (int i = 0; i < 3; i++) run_cycle("wrap_up", 0, 0, 16'h0, 0, 9'h0);
        check_value("wrap_up_const", CounterValue, 16'h0001);

        // Load beats offset; reset interrupts an offset run.
        run_cycle("load_over_offset", 0, 1, 16'h1234, 1, 9'd5);
        check_value("load_over_offset_const", CounterValue, 16'h1234);
        for (int i = 0; i < 2; i++) run_cycle("offset_run", 0, 0, 16'h0, 1, 9'd7);
        run_cycle("reset_offset_run", 1, 0, 16'h0, 1, 9'd7);
        check_value("reset_offset_run_const", CounterValue, 16'h0000);
        run_cycle("resume", 0, 0, 16'h0, 0, 9'h0);
        check_value("resume_const", CounterValue, 16'h0001);

        // Random mix with biased control probabilities.
        for (int i = 0; i < 400; i++) begin
            logic       rst;
            logic       ld;
            logic       oe;
            logic [15:0] lv;
            logic [8:0]  off;
            rst = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            oe  = ($urandom_range(0, 2) == 0);
            lv  = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       off = 9'h000;
                1:       off = 9'h100;
                2:       off = 9'h0FF;
                3:       off = 9'h1FF;
                default: off = 9'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) lv = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
            run_cycle("random", rst, ld, lv, oe, off);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
